// File: rtl/vga_adapter_pkg.sv
// Shared VGA timing constants and the frame-buffer resolution mapping.
package vga_adapter_pkg;

    // 640x480@60 Hz horizontal timing, in pixel ticks
    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    // 640x480@60 Hz vertical timing, in lines
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int CNT_W  = 10;
    localparam int CHAN_W = 10;

    typedef enum logic {
        RES_320X240,
        RES_160X120
    } res_t;

    // Frame-buffer width for a resolution setting
    function automatic int fb_width(input res_t res);
        return (res == RES_160X120) ? 160 : 320;
    endfunction

    // Frame-buffer height for a resolution setting
    function automatic int fb_height(input res_t res);
        return (res == RES_160X120) ? 120 : 240;
    endfunction

    // Right shift from screen coordinates to frame-buffer coordinates
    function automatic int fb_shift(input res_t res);
        return (res == RES_160X120) ? 2 : 1;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel enable, 800x525 scan counters and stage-0 sync/visible decode.
module vga_timing_gen
    import vga_adapter_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    output logic             pe,
    output logic             pix_clk,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             visible
);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);

    // Pixel enable: toggles every system clock, one pixel tick per two clocks
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) pe <= 1'b0;
        else         pe <= ~pe;
    end

    // DAC pixel clock: registered copy of the pixel-enable toggle flop
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) pix_clk <= 1'b0;
        else         pix_clk <= pe;
    end

    // Stage 0: scan counters, vertical advances when the line wraps
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hcount <= '0;
            vcount <= '0;
        end else if (pe) begin
            if (hcount == H_LAST) begin
                hcount <= '0;
                vcount <= (vcount == V_LAST) ? '0 : vcount + CNT_W'(1);
            end else begin
                hcount <= hcount + CNT_W'(1);
            end
        end
    end

    // Stage 0 decode: active-low syncs and the visible-window flag
    always_comb begin
        hsync   = !((hcount >= HS_START) && (hcount < HS_END));
        vsync   = !((vcount >= VS_START) && (vcount < VS_END));
        visible = (hcount < H_VIS) && (vcount < V_VIS);
    end

endmodule

// File: rtl/vga_adapter.sv
// Frame buffer with a single write port, scanned out to the VGA DAC with pixel replication.
module vga_adapter
    import vga_adapter_pkg::*;
#(
    parameter string RESOLUTION              = "320x240",
    parameter string MONOCHROME              = "FALSE",
    parameter int    BITS_PER_COLOUR_CHANNEL = 1,
    parameter string BACKGROUND_IMAGE        = "black.mif"
) (
    input  logic                                 clock,
    input  logic                                 resetn,
    input  logic [3*BITS_PER_COLOUR_CHANNEL-1:0] colour,
    input  logic [9:0]                           x,
    input  logic [9:0]                           y,
    input  logic                                 plot,
    output logic [9:0]                           VGA_R,
    output logic [9:0]                           VGA_G,
    output logic [9:0]                           VGA_B,
    output logic                                 VGA_HS,
    output logic                                 VGA_VS,
    output logic                                 VGA_BLANK,
    output logic                                 VGA_SYNC,
    output logic                                 VGA_CLK
);

    localparam res_t RES    = (RESOLUTION == "160x120") ? RES_160X120 : RES_320X240;
    localparam bit   MONO   = (MONOCHROME == "TRUE");
    localparam int   BPC    = BITS_PER_COLOUR_CHANNEL;
    localparam int   W      = fb_width(RES);
    localparam int   H      = fb_height(RES);
    localparam int   S      = fb_shift(RES);
    localparam int   DEPTH  = W * H;
    localparam int   ADDR_W = $clog2(DEPTH);
    localparam int   MEM_W  = MONO ? 1 : 3 * BPC;
    localparam int   REP    = CHAN_W / BPC;

    // Reject configurations the datapath cannot represent
    if (BPC != 1 && BPC != 2) begin : g_bad_bpc
        $error("BITS_PER_COLOUR_CHANNEL must be 1 or 2");
    end
    if (RESOLUTION != "320x240" && RESOLUTION != "160x120") begin : g_bad_res
        $error("RESOLUTION must be 320x240 or 160x120");
    end
    if (BACKGROUND_IMAGE == "") begin : g_bad_bg
        $error("BACKGROUND_IMAGE must name an initialisation file");
    end

    logic             pe;
    logic [CNT_W-1:0] hcount, vcount;
    logic             hs_p0, vs_p0, vis_p0;
    logic             hs_p1, vs_p1, vis_p1;
    logic             wr_en;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [MEM_W-1:0] wr_data, rd_data_p1;
    logic [BPC-1:0]   r_bits, g_bits, b_bits;
    logic [MEM_W-1:0] fb [DEPTH];

    vga_timing_gen u_timing (
        .clock   (clock),
        .resetn  (resetn),
        .pe      (pe),
        .pix_clk (VGA_CLK),
        .hcount  (hcount),
        .vcount  (vcount),
        .hsync   (hs_p0),
        .vsync   (vs_p0),
        .visible (vis_p0)
    );

    assign VGA_SYNC = 1'b1;

    // Monochrome keeps only colour[0]; channel bits are split out after the read
    if (MONO) begin : g_mono
        assign wr_data = colour[0];
        assign r_bits  = {BPC{rd_data_p1[0]}};
        assign g_bits  = {BPC{rd_data_p1[0]}};
        assign b_bits  = {BPC{rd_data_p1[0]}};
    end else begin : g_colour
        assign wr_data = colour;
        assign r_bits  = rd_data_p1[3*BPC-1 -: BPC];
        assign g_bits  = rd_data_p1[2*BPC-1 -: BPC];
        assign b_bits  = rd_data_p1[BPC-1:0];
    end

    // Write decode and replicated read address; out-of-window reads park at 0
    always_comb begin
        wr_en   = plot && (x < 10'(W)) && (y < 10'(H));
        wr_addr = ADDR_W'(32'(y) * 32'(W) + 32'(x));
        rd_addr = '0;
        if (vis_p0) begin
            rd_addr = ADDR_W'((32'(vcount) >> S) * 32'(W) + (32'(hcount) >> S));
        end
    end

    // Frame-buffer write port; contents survive reset
    always_ff @(posedge clock) begin
        if (wr_en) fb[wr_addr] <= wr_data;
    end

    // Stage 1: frame-buffer read (old data on a same-address collision)
    always_ff @(posedge clock) begin
        if (pe) rd_data_p1 <= fb[rd_addr];
    end

    // Stage 1: sync and visible flag delayed alongside the read
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hs_p1  <= 1'b1;
            vs_p1  <= 1'b1;
            vis_p1 <= 1'b0;
        end else if (pe) begin
            hs_p1  <= hs_p0;
            vs_p1  <= vs_p0;
            vis_p1 <= vis_p0;
        end
    end

    // Stage 2: registered DAC outputs, colour replicated to 10 bits and blanked
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            VGA_HS    <= 1'b1;
            VGA_VS    <= 1'b1;
            VGA_BLANK <= 1'b0;
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
        end else if (pe) begin
            VGA_HS    <= hs_p1;
            VGA_VS    <= vs_p1;
            VGA_BLANK <= vis_p1;
            VGA_R     <= vis_p1 ? {REP{r_bits}} : '0;
            VGA_G     <= vis_p1 ? {REP{g_bits}} : '0;
            VGA_B     <= vis_p1 ? {REP{b_bits}} : '0;
        end
    end

endmodule

// File: tb/tb_vga_adapter.sv
// Bench for vga_adapter: random frame-buffer contents checked pixel by pixel on screen.
module tb_vga_adapter;

    logic       clock  = 1'b0;
    logic       resetn = 1'b1;
    logic [2:0] colour = '0;
    logic [9:0] x      = '0;
    logic [9:0] y      = '0;
    logic       plot   = 1'b0;
    logic [9:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_CLK;

    int checks = 0;
    int errors = 0;
    int cur_k  = 0;

    // Reference frame buffer, 320x240, indexed y*320+x
    logic [2:0] model [0:76799];

    vga_adapter dut (
        .clock     (clock),
        .resetn    (resetn),
        .colour    (colour),
        .x         (x),
        .y         (y),
        .plot      (plot),
        .VGA_R     (VGA_R),
        .VGA_G     (VGA_G),
        .VGA_B     (VGA_B),
        .VGA_HS    (VGA_HS),
        .VGA_VS    (VGA_VS),
        .VGA_BLANK (VGA_BLANK),
        .VGA_SYNC  (VGA_SYNC),
        .VGA_CLK   (VGA_CLK)
    );

    always #10 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed %h, expected %h", tag, cur_k, obs, exp);
        end
    endtask

    function automatic logic [29:0] expand(input logic [2:0] c);
        return {{10{c[2]}}, {10{c[1]}}, {10{c[0]}}};
    endfunction

    // One write per clock; only in-window coordinates reach the model
    task automatic plot_px(input int px, input int py, input logic [2:0] c);
        x      = 10'(px);
        y      = 10'(py);
        colour = c;
        plot   = 1'b1;
        @(negedge clock);
        if (px < 320 && py < 240) model[py*320 + px] = c;
    endtask

    task automatic check_reset(input string tag);
        cur_k = 0;
        check({tag, "_ctl"}, 32'({VGA_SYNC, VGA_HS, VGA_VS, VGA_BLANK}), 32'(4'b1110));
        check({tag, "_rgb"}, 32'({VGA_R, VGA_G, VGA_B}), 32'(0));
        check({tag, "_clk"}, 32'(VGA_CLK), 32'(0));
    endtask

    // Sample after each clock edge since reset release; pixel p is shown after edge 4+2p
    task automatic scan(input string pass, input int nedges);
        int   falls[$];
        int   rises[$];
        logic prev_hs = 1'b1;
        int   blank_hi = 0;
        for (int k = 1; k <= nedges; k++) begin
            logic [3:0]  exp_ctl;
            logic [29:0] exp_rgb;
            @(negedge clock);
            cur_k   = k;
            exp_ctl = 4'b1110;
            exp_rgb = '0;
            if (k >= 4) begin
                int p, h, v;
                p = (k - 4) / 2;
                h = p % 800;
                v = p / 800;
                exp_ctl = {1'b1, !(h >= 656 && h < 752), !(v >= 490 && v < 492),
                           (h < 640 && v < 480)};
                if (exp_ctl[0]) exp_rgb = expand(model[(v / 2) * 320 + h / 2]);
            end
            check({pass, "_clk"}, 32'(VGA_CLK), 32'(k % 2 == 0));
            check({pass, "_ctl"}, 32'({VGA_SYNC, VGA_HS, VGA_VS, VGA_BLANK}), 32'(exp_ctl));
            check({pass, "_rgb"}, 32'({VGA_R, VGA_G, VGA_B}), 32'(exp_rgb));
            if (prev_hs && !VGA_HS) falls.push_back(k);
            if (!prev_hs && VGA_HS) rises.push_back(k);
            prev_hs = VGA_HS;
            if (k >= 4 && k < 1604 && VGA_BLANK) blank_hi++;
        end
        cur_k = nedges;
        check({pass, "_hs_edges_seen"}, 32'({falls.size() >= 2, rises.size() >= 1}), 32'(2'b11));
        if (falls.size() >= 2 && rises.size() >= 1) begin
            check({pass, "_first_hs_fall"}, 32'(falls[0]), 32'(656 * 2 + 4));
            check({pass, "_hs_low"}, 32'(rises[0] - falls[0]), 32'(192));
            check({pass, "_hs_period"}, 32'(falls[1] - falls[0]), 32'(1600));
        end
        check({pass, "_blank_hi_line0"}, 32'(blank_hi), 32'(1280));
    endtask

    initial begin
        for (int i = 0; i < 76800; i++) model[i] = '0;

        #5 resetn = 1'b0;
        #1 check_reset("initial_reset");
        @(negedge clock);

        // Back-to-back random fill of buffer rows 0..12 while held in reset
        for (int py = 0; py < 13; py++) begin
            for (int px = 0; px < 320; px++) begin
                plot_px(px, py, 3'($urandom_range(0, 7)));
            end
        end
        plot_px(0, 0, 3'b111);
        plot_px(319, 5, 3'b010);
        plot_px(0, 1, 3'b000);
        plot_px(0, 2, 3'b000);
        // Out-of-range writes that would alias onto rows 1 and 2 if wrapped
        plot_px(320, 0, 3'b111);
        plot_px(640, 0, 3'b111);
        plot_px(5, 240, 3'b111);
        plot_px(1023, 3, 3'b111);
        plot   = 1'b0;
        resetn = 1'b1;

        // 24 full lines plus part of line 24, ending on a visible pixel
        scan("pass1", 4 + 2 * (24 * 800 + 100));

        // Asynchronous reset mid-line
        #3 resetn = 1'b0;
        #1 check_reset("midline_reset");
        @(negedge clock);

        // New pixels during reset; earlier contents must survive
        for (int i = 0; i < 24; i++) begin
            plot_px(int'($urandom_range(0, 319)), int'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)));
        end
        plot_px(319, 1, 3'b010);
        plot   = 1'b0;
        resetn = 1'b1;

        scan("pass2", 4 + 2 * 800 * 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
